tru_readout_sequencer: RTL and testbench

Sequences readout of the TRU 256-entry sample ring buffer once the write side has frozen it after an L2 accept. On a start pulse it reads a fixed window of samples beginning PRE_SAMPLES before the latched L0 address, wrapping modulo buffer depth. It streams the samples downstream under a valid/ready handshake and pulses `readout_end` when the last word has been accepted. It sits between the buffer RAM read port and the board readout FIFO.

---
 rtl/tru_pkg.sv | 13 +
 rtl/tru_readout_sequencer_if.sv | 25 ++
 rtl/tru_skid_fifo.sv | 53 +++++
 rtl/tru_readout_sequencer.sv | 137 +++++++++++++
 tb/tb_tru_readout_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tru_pkg.sv
// Shared TRU readout types and default geometry.
package tru_pkg;
  localparam int TRU_ADDR_W      = 8;
  localparam int TRU_DATA_W      = 16;
  localparam int TRU_PRE_SAMPLES = 16;
  localparam int TRU_NSAMPLES    = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tru_state_e;
endpackage

// File: rtl/tru_readout_sequencer_if.sv
// Ring-buffer read port plus downstream sample stream of the TRU readout sequencer.
interface tru_readout_sequencer_if
  import tru_pkg::*;
#(
  parameter int ADDR_W = TRU_ADDR_W,
  parameter int DATA_W = TRU_DATA_W
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_addr, rd_en, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, rd_en, out_data, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/tru_skid_fifo.sv
// Two-entry skid FIFO: registered head drives the output, second slot absorbs one extra word.
module tru_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;
  logic         head_vld_q;
  logic         skid_vld_q;
  logic         pop;
  logic         push;

  assign pop        = head_vld_q & out_ready_i;
  assign in_ready_o = ~skid_vld_q | pop;
  assign push       = in_valid_i & in_ready_o;

  assign out_valid_o = head_vld_q;
  assign out_data_o  = head_q;
  assign count_o     = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (!head_vld_q || pop) begin
        // Head is free this edge: refill from the skid slot first to keep order.
        if (skid_vld_q) begin
          head_q     <= skid_q;
          head_vld_q <= 1'b1;
          skid_vld_q <= push;
          if (push) skid_q <= in_data_i;
        end else begin
          head_vld_q <= push;
          if (push) head_q <= in_data_i;
        end
      end else if (push) begin
        skid_q     <= in_data_i;
        skid_vld_q <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/tru_readout_sequencer.sv
// TRU ring-buffer readout sequencer: streams NSAMPLES words starting PRE_SAMPLES before L0.
// Define TRU_READOUT_HEADER_EN to prepend a {base, address_L0} header word to each readout.
module tru_readout_sequencer
  import tru_pkg::*;
#(
  parameter int ADDR_W      = TRU_ADDR_W,
  parameter int DATA_W      = TRU_DATA_W,
  parameter int PRE_SAMPLES = TRU_PRE_SAMPLES,
  parameter int NSAMPLES    = TRU_NSAMPLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       address_L0,
  output logic                    busy,
  output logic                    readout_end,
  tru_readout_sequencer_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] NS_C  = CNT_W'(NSAMPLES);
  localparam logic [CNT_W-1:0] NS_M1 = CNT_W'(NSAMPLES - 1);
`ifdef TRU_READOUT_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  tru_state_e        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  rcnt_q;
  logic [CNT_W-1:0]  ocnt_q;
  logic              busy_q;
  logic              readout_end_q;
  logic              hdr_q;
  logic              rd_vld_p1_q;
  logic              rd_last_p1_q;

  logic [ADDR_W-1:0] start_base;
  logic [DATA_W-1:0] hdr_word;
  logic              start_ok;
  logic              hdr_push;
  logic              rd_fire;
  logic              credit_ok;
  logic              fifo_in_vld;
  logic              fifo_in_rdy;
  logic              fifo_out_vld;
  logic              fifo_pop;
  logic              sample_pop;
  logic [DATA_W:0]   fifo_in_data;
  logic [DATA_W:0]   fifo_out_data;
  logic [1:0]        fifo_cnt;

  assign start_ok   = (state_q == ST_IDLE) && start;
  assign start_base = address_L0 - ADDR_W'(PRE_SAMPLES);
  assign hdr_word   = DATA_W'({start_base, address_L0});
  assign hdr_push   = HDR_EN && start_ok;

  assign fifo_pop   = fifo_out_vld & bus.out_ready;
  assign sample_pop = fifo_pop & ~hdr_q;

  // Read issue is combinational so a pop in this cycle frees credit immediately;
  // that is what lets the 2-entry FIFO sustain one word per cycle.
  assign credit_ok = ({1'b0, fifo_cnt} + {2'b0, rd_vld_p1_q}) < (3'd2 + {2'b0, fifo_pop});
  assign rd_fire   = (state_q == ST_STREAM) && (rcnt_q < NS_C) && credit_ok && fifo_in_rdy;

  assign bus.rd_en   = rd_fire;
  assign bus.rd_addr = base_q + rcnt_q[ADDR_W-1:0];

  assign fifo_in_vld  = hdr_push | rd_vld_p1_q;
  assign fifo_in_data = hdr_push ? {1'b0, hdr_word} : {rd_last_p1_q, bus.rd_data};

  assign bus.out_valid = fifo_out_vld;
  assign bus.out_data  = fifo_out_data[DATA_W-1:0];
  assign bus.out_last  = fifo_out_data[DATA_W];

  assign busy        = busy_q;
  assign readout_end = readout_end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      rcnt_q        <= '0;
      ocnt_q        <= '0;
      busy_q        <= 1'b0;
      readout_end_q <= 1'b0;
      hdr_q         <= 1'b0;
      rd_vld_p1_q   <= 1'b0;
      rd_last_p1_q  <= 1'b0;
    end else begin
      // p1: RAM data for the read issued last cycle is on rd_data now.
      rd_vld_p1_q   <= rd_fire;
      rd_last_p1_q  <= rd_fire && (rcnt_q == NS_M1);
      readout_end_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_STREAM;
            base_q  <= start_base;
            rcnt_q  <= '0;
            ocnt_q  <= '0;
            busy_q  <= 1'b1;
            hdr_q   <= HDR_EN;
          end
        end
        ST_STREAM: begin
          if (rd_fire) rcnt_q <= rcnt_q + CNT_W'(1);
          if (fifo_pop && hdr_q) hdr_q <= 1'b0;
          if (sample_pop) begin
            ocnt_q <= ocnt_q + CNT_W'(1);
            if (ocnt_q == NS_M1) begin
              state_q       <= ST_DONE;
              busy_q        <= 1'b0;
              readout_end_q <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tru_skid_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (fifo_in_vld),
    .in_ready_o (fifo_in_rdy),
    .in_data_i  (fifo_in_data),
    .out_valid_o(fifo_out_vld),
    .out_ready_i(bus.out_ready),
    .out_data_o (fifo_out_data),
    .count_o    (fifo_cnt)
  );
endmodule

// File: tb/tb_tru_readout_sequencer.sv
// Directed bench for tru_readout_sequencer: window addressing, wrap, backpressure, start/reset abuse.
module tb_tru_readout_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] address_L0;
  logic       busy;
  logic       readout_end;

  tru_readout_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  tru_readout_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .address_L0 (address_L0),
    .busy       (busy),
    .readout_end(readout_end),
    .bus        (bus)
  );

`ifdef TRU_READOUT_HEADER_EN
  localparam bit HDR = 1'b1;
  localparam int FIRST_VLD = 1;
`else
  localparam bit HDR = 1'b0;
  localparam int FIRST_VLD = 3;
`endif

  int          total = 0;
  int          bad = 0;
  logic [15:0] mem [256];
  bit          pat_cnt;
  logic [7:0]  addr_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (!reset && bus.rd_en) addr_q.push_back(bus.rd_addr);
  end

  function automatic logic [15:0] pat(input logic [7:0] a);
    return pat_cnt ? {8'h00, a} : {~a, a};
  endfunction

  task automatic fill(input bit cnt);
    pat_cnt = cnt;
    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'h0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'h0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_readout_end"}, 32'(readout_end), 32'h0);
  endtask

  // One readout from l0; abort_at >= 0 applies reset after that many samples.
  task automatic readout(input logic [7:0] l0, input bit rnd, input bit glitch, input int abort_at);
    logic [7:0]  base;
    logic [7:0]  ea;
    logic [15:0] pdata;
    bit          pstall;
    bit          hdr_pending;
    bit          gdone;
    int          k;
    int          cyc;
    int          first_cyc;
    int          acc_cyc;
    base = l0 - 8'd16;
    addr_q.delete();
    k = 0; cyc = 0; first_cyc = -1; acc_cyc = -1;
    pstall = 1'b0; pdata = '0; hdr_pending = HDR; gdone = 1'b0;
    address_L0 = l0;
    start = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (k < 128 && cyc < 3000 && !(abort_at >= 0 && k == abort_at)) begin
      start = 1'b0;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 1) begin
        chk("busy_t1", 32'(busy), 32'h1);
        chk("rd_en_t1", 32'(bus.rd_en), 32'h1);
        chk("rd_addr_t1", 32'(bus.rd_addr), 32'(base));
      end
      if (pstall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'h1);
        chk("hold_data", 32'(bus.out_data), 32'(pdata));
      end
      if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
      if (glitch && k == 20 && !gdone) begin
        start = 1'b1;
        address_L0 = 8'h99;
        gdone = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (hdr_pending) begin
          chk("header", 32'(bus.out_data), 32'({base, l0}));
          chk("header_last", 32'(bus.out_last), 32'h0);
          hdr_pending = 1'b0;
        end else begin
          ea = base + 8'(k);
          chk("data", 32'(bus.out_data), 32'(pat(ea)));
          chk("last", 32'(bus.out_last), 32'(k == 127));
          k++;
          acc_cyc = cyc;
        end
      end
      pstall = bus.out_valid && !bus.out_ready;
      pdata  = bus.out_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_count", 32'(k), 32'(abort_at));
      reset = 1'b1;
      @(negedge clk);
      chk_zero_outputs("midreset");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("no_end_after_reset", 32'(readout_end), 32'h0);
      end
      chk("idle_after_reset", 32'(busy), 32'h0);
    end else begin
      chk("words", 32'(k), 32'd128);
      chk("readout_end", 32'(readout_end), 32'h1);
      chk("busy_at_end", 32'(busy), 32'h0);
      if (!rnd) begin
        chk("first_valid_cyc", 32'(first_cyc), 32'(FIRST_VLD));
        chk("last_accept_cyc", 32'(acc_cyc), 32'd130);
      end
      if (glitch) begin
        start = 1'b1;
        address_L0 = 8'h77;
      end
      @(negedge clk);
      start = 1'b0;
      chk("end_one_cycle", 32'(readout_end), 32'h0);
      chk("busy_idle", 32'(busy), 32'h0);
      chk("n_reads", 32'(addr_q.size()), 32'd128);
      for (int i = 0; i < 128 && i < addr_q.size(); i++) begin
        ea = base + 8'(i);
        chk("rd_addr_seq", 32'(addr_q[i]), 32'(ea));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    address_L0 = '0;
    bus.out_ready = 1'b0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    readout(8'h40, 1'b0, 1'b0, -1);
    readout(8'h05, 1'b0, 1'b0, -1);
    fill(1'b1);
    readout(8'h40, 1'b1, 1'b0, -1);
    fill(1'b0);
    readout(8'h40, 1'b0, 1'b1, -1);
    readout(8'h40, 1'b0, 1'b0, 50);
    readout(8'h40, 1'b0, 1'b0, -1);
    readout(8'hC3, 1'b1, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
